// File: rtl/kdtree_load_ctrl.sv
// kdtree_load_ctrl: drains the input word stream (nodes -> leaves -> queries) into the three accelerator stores.
// Latency: each *_wen pulses one cycle after the entry's last word is popped. load_done follows one cycle after the final query write.
// Backpressure: pops only while busy and the FIFO is non-empty. An empty FIFO stalls every counter and pack register in place.
//
// Ports:
//   clk, rst_n                       core clock, async active-low reset
//   load_kdtree                      1-cycle start pulse (ignored while busy)
//   in_fifo_rempty_n/rdata/deq       first-word-fall-through FIFO head and pop
//   node_wen/waddr/wdata             internal-node regfile write {median, split index}
//   leaf_wen/waddr/wpatch/wdata/widx leaf patch SRAM write (element 0 in LSBs)
//   query_wen/waddr/wdata            query patch SRAM write (element 0 in LSBs)
//   busy, load_done                  status; load_done gates the search FSM start
module kdtree_load_ctrl #(
  parameter int DATA_WIDTH = 11,
  parameter int PATCH_SIZE = 5,
  parameter int LEAF_SIZE  = 8,
  parameter int NUM_LEAVES = 64,
  parameter int NUM_QUERYS = 494
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                load_kdtree,
  input  logic                                in_fifo_rempty_n,
  input  logic [DATA_WIDTH-1:0]               in_fifo_rdata,
  output logic                                in_fifo_deq,
  output logic                                node_wen,
  output logic [$clog2(NUM_LEAVES-1)-1:0]     node_waddr,
  output logic [2*DATA_WIDTH-1:0]             node_wdata,
  output logic                                leaf_wen,
  output logic [$clog2(NUM_LEAVES)-1:0]       leaf_waddr,
  output logic [$clog2(LEAF_SIZE)-1:0]        leaf_wpatch,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]    leaf_wdata,
  output logic [DATA_WIDTH-1:0]               leaf_widx,
  output logic                                query_wen,
  output logic [$clog2(NUM_QUERYS)-1:0]       query_waddr,
  output logic [PATCH_SIZE*DATA_WIDTH-1:0]    query_wdata,
  output logic                                busy,
  output logic                                load_done
);

  localparam int NUM_NODES = NUM_LEAVES - 1;
  localparam int NODE_AW   = $clog2(NUM_NODES);
  localparam int LEAF_AW   = $clog2(NUM_LEAVES);
  localparam int PATCH_AW  = $clog2(LEAF_SIZE);
  localparam int QUERY_AW  = $clog2(NUM_QUERYS);
  localparam int PATCH_W   = PATCH_SIZE * DATA_WIDTH;
  // Word-within-entry counter must reach PATCH_SIZE (leaf index word).
  localparam int WORD_CW   = $clog2(PATCH_SIZE + 1);

  // Position of the final word of one entry in each section.
  localparam logic [WORD_CW-1:0] NODE_LAST_WORD  = WORD_CW'(1);
  localparam logic [WORD_CW-1:0] LEAF_LAST_WORD  = WORD_CW'(PATCH_SIZE);
  localparam logic [WORD_CW-1:0] QUERY_LAST_WORD = WORD_CW'(PATCH_SIZE - 1);

  // Final entry of each section.
  localparam logic [NODE_AW-1:0]  NODE_LAST  = NODE_AW'(NUM_NODES - 1);
  localparam logic [LEAF_AW-1:0]  LEAF_LAST  = LEAF_AW'(NUM_LEAVES - 1);
  localparam logic [PATCH_AW-1:0] PATCH_LAST = PATCH_AW'(LEAF_SIZE - 1);
  localparam logic [QUERY_AW-1:0] QUERY_LAST = QUERY_AW'(NUM_QUERYS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_NODE  = 3'd1,
    LD_LEAF  = 3'd2,
    LD_QUERY = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [WORD_CW-1:0]    word_q, word_d;
  logic [NODE_AW-1:0]    node_cnt_q, node_cnt_d;
  logic [LEAF_AW-1:0]    leaf_cnt_q, leaf_cnt_d;
  logic [PATCH_AW-1:0]   patch_cnt_q, patch_cnt_d;
  logic [QUERY_AW-1:0]   query_cnt_q, query_cnt_d;
  logic [PATCH_W-1:0]    pack_q, pack_d;
  logic                  load_done_q, load_done_d;

  // Registered write ports.
  logic                  node_wen_q, node_wen_d;
  logic [NODE_AW-1:0]    node_waddr_q, node_waddr_d;
  logic [2*DATA_WIDTH-1:0] node_wdata_q, node_wdata_d;
  logic                  leaf_wen_q, leaf_wen_d;
  logic [LEAF_AW-1:0]    leaf_waddr_q, leaf_waddr_d;
  logic [PATCH_AW-1:0]   leaf_wpatch_q, leaf_wpatch_d;
  logic [PATCH_W-1:0]    leaf_wdata_q, leaf_wdata_d;
  logic [DATA_WIDTH-1:0] leaf_widx_q, leaf_widx_d;
  logic                  query_wen_q, query_wen_d;
  logic [QUERY_AW-1:0]   query_waddr_q, query_waddr_d;
  logic [PATCH_W-1:0]    query_wdata_q, query_wdata_d;

  logic busy_w;
  logic pop;
  logic last_word;

  assign busy_w = (state_q == LD_NODE) || (state_q == LD_LEAF) || (state_q == LD_QUERY);
  assign pop    = in_fifo_rempty_n & busy_w;

  always_comb begin
    last_word = 1'b0;
    case (state_q)
      LD_NODE:  last_word = (word_q == NODE_LAST_WORD);
      LD_LEAF:  last_word = (word_q == LEAF_LAST_WORD);
      LD_QUERY: last_word = (word_q == QUERY_LAST_WORD);
      default:  last_word = 1'b0;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    word_d        = word_q;
    node_cnt_d    = node_cnt_q;
    leaf_cnt_d    = leaf_cnt_q;
    patch_cnt_d   = patch_cnt_q;
    query_cnt_d   = query_cnt_q;
    pack_d        = pack_q;
    load_done_d   = load_done_q;
    node_wen_d    = 1'b0;
    node_waddr_d  = node_waddr_q;
    node_wdata_d  = node_wdata_q;
    leaf_wen_d    = 1'b0;
    leaf_waddr_d  = leaf_waddr_q;
    leaf_wpatch_d = leaf_wpatch_q;
    leaf_wdata_d  = leaf_wdata_q;
    leaf_widx_d   = leaf_widx_q;
    query_wen_d   = 1'b0;
    query_waddr_d = query_waddr_q;
    query_wdata_d = query_wdata_q;

    case (state_q)
      IDLE, DONE: begin
        if (load_kdtree) begin
          state_d     = LD_NODE;
          word_d      = '0;
          node_cnt_d  = '0;
          leaf_cnt_d  = '0;
          patch_cnt_d = '0;
          query_cnt_d = '0;
          pack_d      = '0;
          load_done_d = 1'b0;
        end else if (state_q == DONE) begin
          // DONE is entered together with the last query write, so this
          // lands load_done one cycle after that write strobe.
          load_done_d = 1'b1;
        end
      end

      LD_NODE: begin
        if (pop && last_word) begin
          node_wen_d   = 1'b1;
          node_waddr_d = node_cnt_q;
          node_wdata_d = {in_fifo_rdata, pack_q[DATA_WIDTH-1:0]};
          word_d       = '0;
          if (node_cnt_q == NODE_LAST) state_d = LD_LEAF;
          else                         node_cnt_d = node_cnt_q + 1'b1;
        end
      end

      LD_LEAF: begin
        if (pop && last_word) begin
          // The sixth word is the patch's image index, not an element.
          leaf_wen_d    = 1'b1;
          leaf_waddr_d  = leaf_cnt_q;
          leaf_wpatch_d = patch_cnt_q;
          leaf_wdata_d  = pack_q;
          leaf_widx_d   = in_fifo_rdata;
          word_d        = '0;
          if (patch_cnt_q == PATCH_LAST) begin
            if (leaf_cnt_q == LEAF_LAST) begin
              state_d = LD_QUERY;
            end else begin
              leaf_cnt_d  = leaf_cnt_q + 1'b1;
              patch_cnt_d = '0;
            end
          end else begin
            patch_cnt_d = patch_cnt_q + 1'b1;
          end
        end
      end

      LD_QUERY: begin
        if (pop && last_word) begin
          query_wen_d   = 1'b1;
          query_waddr_d = query_cnt_q;
          query_wdata_d = {in_fifo_rdata, pack_q[PATCH_W-DATA_WIDTH-1:0]};
          word_d        = '0;
          if (query_cnt_q == QUERY_LAST) state_d = DONE;
          else                           query_cnt_d = query_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    // Non-final words accumulate into slice word_q; the final word bypasses
    // the pack register straight into the write data.
    if (pop && !last_word) begin
      word_d = word_q + 1'b1;
      for (int k = 0; k < PATCH_SIZE; k++) begin
        if (word_q == WORD_CW'(k)) pack_d[k*DATA_WIDTH +: DATA_WIDTH] = in_fifo_rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      word_q        <= '0;
      node_cnt_q    <= '0;
      leaf_cnt_q    <= '0;
      patch_cnt_q   <= '0;
      query_cnt_q   <= '0;
      pack_q        <= '0;
      load_done_q   <= 1'b0;
      node_wen_q    <= 1'b0;
      node_waddr_q  <= '0;
      node_wdata_q  <= '0;
      leaf_wen_q    <= 1'b0;
      leaf_waddr_q  <= '0;
      leaf_wpatch_q <= '0;
      leaf_wdata_q  <= '0;
      leaf_widx_q   <= '0;
      query_wen_q   <= 1'b0;
      query_waddr_q <= '0;
      query_wdata_q <= '0;
    end else begin
      state_q       <= state_d;
      word_q        <= word_d;
      node_cnt_q    <= node_cnt_d;
      leaf_cnt_q    <= leaf_cnt_d;
      patch_cnt_q   <= patch_cnt_d;
      query_cnt_q   <= query_cnt_d;
      pack_q        <= pack_d;
      load_done_q   <= load_done_d;
      node_wen_q    <= node_wen_d;
      node_waddr_q  <= node_waddr_d;
      node_wdata_q  <= node_wdata_d;
      leaf_wen_q    <= leaf_wen_d;
      leaf_waddr_q  <= leaf_waddr_d;
      leaf_wpatch_q <= leaf_wpatch_d;
      leaf_wdata_q  <= leaf_wdata_d;
      leaf_widx_q   <= leaf_widx_d;
      query_wen_q   <= query_wen_d;
      query_waddr_q <= query_waddr_d;
      query_wdata_q <= query_wdata_d;
    end
  end

  assign in_fifo_deq = pop;
  assign busy        = busy_w;
  assign load_done   = load_done_q;
  assign node_wen    = node_wen_q;
  assign node_waddr  = node_waddr_q;
  assign node_wdata  = node_wdata_q;
  assign leaf_wen    = leaf_wen_q;
  assign leaf_waddr  = leaf_waddr_q;
  assign leaf_wpatch = leaf_wpatch_q;
  assign leaf_wdata  = leaf_wdata_q;
  assign leaf_widx   = leaf_widx_q;
  assign query_wen   = query_wen_q;
  assign query_waddr = query_waddr_q;
  assign query_wdata = query_wdata_q;

endmodule
